isram_port_arbiter: RTL and testbench

- Shares the single-port instruction SRAM between two requesters.
- Requester 0 is the CPU instruction-fetch port (read-only); requester 1 is the boot/debug loader port (read/write).
- Sits between the requesters and the SRAM macro and drives the SRAM ADDR/WDATA/WREN/CS pins directly.
- Fixed priority to fetch, starvation guard for the loader, and a boot-hold mode that locks fetch out while the loader fills the memory.

---
 rtl/isram_arb_pkg.sv | 20 ++
 rtl/isram_port_arbiter_if.sv | 45 ++++
 rtl/isram_starve_counter.sv | 47 ++++
 rtl/isram_port_arbiter.sv | 102 ++++++++++
 tb/tb_isram_port_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/isram_arb_pkg.sv
// ---------------------------------------------------------------------------
// isram_arb_pkg : shared types and constants for the instruction-SRAM arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package isram_arb_pkg;

  localparam int WAIT_W = 8;

  // Which requester owns the read data returning from the SRAM this cycle
  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LOADER = 2'd2
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/isram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// isram_port_arbiter_if : fetch/loader request ports and SRAM macro pins
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface isram_port_arbiter_if #(
  parameter int AW = 16
);

  logic            BOOT_HOLD;
  logic            F_REQ;
  logic [AW-3:0]   F_ADDR;
  logic            F_GNT;
  logic            F_RVALID;
  logic [31:0]     F_RDATA;
  logic            L_REQ;
  logic            L_WRITE;
  logic [AW-3:0]   L_ADDR;
  logic [3:0]      L_BE;
  logic [31:0]     L_WDATA;
  logic            L_GNT;
  logic            L_RVALID;
  logic [31:0]     L_RDATA;
  logic [AW-3:0]   SRAMADDR;
  logic [31:0]     SRAMWDATA;
  logic [3:0]      SRAMWEN;
  logic            SRAMCS;
  logic [31:0]     SRAMRDATA;

  modport slave (
    input  BOOT_HOLD, F_REQ, F_ADDR, L_REQ, L_WRITE, L_ADDR, L_BE, L_WDATA, SRAMRDATA,
    output F_GNT, F_RVALID, F_RDATA, L_GNT, L_RVALID, L_RDATA,
           SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
  );

  modport master (
    output BOOT_HOLD, F_REQ, F_ADDR, L_REQ, L_WRITE, L_ADDR, L_BE, L_WDATA, SRAMRDATA,
    input  F_GNT, F_RVALID, F_RDATA, L_GNT, L_RVALID, L_RDATA,
           SRAMADDR, SRAMWDATA, SRAMWEN, SRAMCS
  );

endinterface

`default_nettype wire

// File: rtl/isram_starve_counter.sv
// ---------------------------------------------------------------------------
// isram_starve_counter : saturating count of cycles the loader has been blocked
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module isram_starve_counter
  import isram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic l_req,
  input  logic l_gnt,
  output logic at_max
);

  localparam logic [WAIT_W-1:0] C_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              clear;

  assign at_max = (wait_cnt_q == C_MAX);
  assign clear  = !l_req || l_gnt;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (!at_max) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/isram_port_arbiter.sv
// ---------------------------------------------------------------------------
// isram_port_arbiter : shares one instruction SRAM between fetch and loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module isram_port_arbiter
  import isram_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  isram_port_arbiter_if.slave  bus
);

  logic          f_gnt;
  logic          l_gnt;
  logic          at_max;
  logic [AW-3:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wen;
  logic          sram_cs;
  owner_e        owner_q;
  owner_e        owner_d;

  isram_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (HCLK),
    .rst    (HRESET),
    .l_req  (bus.L_REQ),
    .l_gnt  (l_gnt),
    .at_max (at_max)
  );

  // Fetch has priority unless the loader has been starved for MAX_WAIT cycles
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!HRESET) begin
      if (bus.BOOT_HOLD) begin
        l_gnt = bus.L_REQ;
      end else if (bus.F_REQ && bus.L_REQ) begin
        l_gnt = at_max;
        f_gnt = !at_max;
      end else begin
        f_gnt = bus.F_REQ;
        l_gnt = bus.L_REQ;
      end
    end
  end

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wen   = 4'b0000;
    sram_cs    = 1'b0;
    if (f_gnt) begin
      sram_addr = bus.F_ADDR;
      sram_cs   = 1'b1;
    end else if (l_gnt) begin
      sram_addr  = bus.L_ADDR;
      sram_wdata = bus.L_WDATA;
      sram_wen   = bus.L_WRITE ? bus.L_BE : 4'b0000;
      sram_cs    = 1'b1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt && !bus.L_WRITE) begin
      owner_d = OWN_LOADER;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.F_GNT     = f_gnt;
  assign bus.L_GNT     = l_gnt;
  assign bus.SRAMADDR  = sram_addr;
  assign bus.SRAMWDATA = sram_wdata;
  assign bus.SRAMWEN   = sram_wen;
  assign bus.SRAMCS    = sram_cs;

  assign bus.F_RVALID  = (owner_q == OWN_FETCH);
  assign bus.L_RVALID  = (owner_q == OWN_LOADER);
  assign bus.F_RDATA   = (owner_q == OWN_FETCH)  ? bus.SRAMRDATA : 32'h0;
  assign bus.L_RDATA   = (owner_q == OWN_LOADER) ? bus.SRAMRDATA : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_isram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_isram_port_arbiter : directed vector bench for isram_port_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_isram_port_arbiter;

  logic HCLK;
  logic HRESET;

  isram_port_arbiter_if #(.AW(16)) bus ();

  isram_port_arbiter #(
    .AW       (16),
    .MAX_WAIT (8)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        rst;
    logic        bh;
    logic        freq;
    logic [13:0] faddr;
    logic        lreq;
    logic        lwr;
    logic [13:0] laddr;
    logic [3:0]  lbe;
    logic [31:0] lwd;
    logic [31:0] srd;
    logic        fg;
    logic        lg;
    logic        fv;
    logic [31:0] frd;
    logic        lv;
    logic [31:0] lrd;
    logic [13:0] sa;
    logic [31:0] swd;
    logic [3:0]  swen;
    logic        scs;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  logic pf    = 1'b0;
  logic pl    = 1'b0;
  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t x, input string tag);
    HRESET        = x.rst;
    bus.BOOT_HOLD = x.bh;
    bus.F_REQ     = x.freq;
    bus.F_ADDR    = x.faddr;
    bus.L_REQ     = x.lreq;
    bus.L_WRITE   = x.lwr;
    bus.L_ADDR    = x.laddr;
    bus.L_BE      = x.lbe;
    bus.L_WDATA   = x.lwd;
    bus.SRAMRDATA = x.srd;
    @(negedge HCLK);
    chk({tag, ".f_gnt"},     32'(bus.F_GNT),     32'(x.fg));
    chk({tag, ".l_gnt"},     32'(bus.L_GNT),     32'(x.lg));
    chk({tag, ".f_rvalid"},  32'(bus.F_RVALID),  32'(x.fv));
    chk({tag, ".f_rdata"},   bus.F_RDATA,        x.frd);
    chk({tag, ".l_rvalid"},  32'(bus.L_RVALID),  32'(x.lv));
    chk({tag, ".l_rdata"},   bus.L_RDATA,        x.lrd);
    chk({tag, ".sramaddr"},  32'(bus.SRAMADDR),  32'(x.sa));
    chk({tag, ".sramwdata"}, bus.SRAMWDATA,      x.swd);
    chk({tag, ".sramwen"},   32'(bus.SRAMWEN),   32'(x.swen));
    chk({tag, ".sramcs"},    32'(bus.SRAMCS),    32'(x.scs));
    @(posedge HCLK);
    #1;
  endtask

  // Derive pin and return expectations from the chosen grant and the previous read owner
  task automatic fill(inout vec_t x);
    x.scs  = x.fg | x.lg;
    x.sa   = x.fg ? x.faddr : (x.lg ? x.laddr : 14'h0);
    x.swd  = x.lg ? x.lwd : 32'h0;
    x.swen = (x.lg && x.lwr) ? x.lbe : 4'h0;
    x.fv   = pf;
    x.frd  = pf ? x.srd : 32'h0;
    x.lv   = pl;
    x.lrd  = pl ? x.srd : 32'h0;
    pf     = x.fg && !x.rst;
    pl     = x.lg && !x.lwr && !x.rst;
  endtask

  initial begin
    HRESET = 1'b1;
    v = '0;
    bus.BOOT_HOLD = 1'b0; bus.F_REQ = 1'b0; bus.F_ADDR = '0; bus.L_REQ = 1'b0;
    bus.L_WRITE = 1'b0; bus.L_ADDR = '0; bus.L_BE = '0; bus.L_WDATA = '0; bus.SRAMRDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;

    // reset held with a pending fetch: everything quiet
    v = '0; v.rst = 1; v.freq = 1; v.faddr = 14'h10; v.srd = 32'h1111_1111; tbl.push_back(v);
    // fetch only, address 0x10, four cycles
    v = '0; v.freq = 1; v.faddr = 14'h10; v.srd = 32'h1000_0001; v.fg = 1; v.sa = 14'h10; v.scs = 1; tbl.push_back(v);
    v.srd = 32'h1000_0002; v.fv = 1; v.frd = 32'h1000_0002; tbl.push_back(v);
    v.srd = 32'h1000_0003; v.frd = 32'h1000_0003; tbl.push_back(v);
    v.srd = 32'h1000_0004; v.frd = 32'h1000_0004; tbl.push_back(v);
    // loader write while last fetch data returns
    v = '0; v.lreq = 1; v.lwr = 1; v.laddr = 14'h3; v.lbe = 4'b0101; v.lwd = 32'hA5A5_5A5A;
    v.srd = 32'hDEAD_0005; v.lg = 1; v.sa = 14'h3; v.swd = 32'hA5A5_5A5A; v.swen = 4'b0101; v.scs = 1;
    v.fv = 1; v.frd = 32'hDEAD_0005; tbl.push_back(v);
    // idle: write produced no read return
    v = '0; v.srd = 32'h0000_0066; tbl.push_back(v);
    // loader read
    v = '0; v.lreq = 1; v.laddr = 14'h7; v.srd = 32'h0000_0077; v.lg = 1; v.sa = 14'h7; v.scs = 1; tbl.push_back(v);
    // boot hold with both requesting: loader every cycle
    v = '0; v.bh = 1; v.freq = 1; v.faddr = 14'h20; v.lreq = 1; v.laddr = 14'h8; v.srd = 32'h8888_8888;
    v.lg = 1; v.sa = 14'h8; v.scs = 1; v.lv = 1; v.lrd = 32'h8888_8888; tbl.push_back(v);
    v.srd = 32'h0000_0099; v.lrd = 32'h0000_0099; tbl.push_back(v);
    // drop boot hold: fetch wins in the same cycle
    v = '0; v.freq = 1; v.faddr = 14'h20; v.lreq = 1; v.laddr = 14'h8; v.srd = 32'h0000_00AA;
    v.fg = 1; v.sa = 14'h20; v.scs = 1; v.lv = 1; v.lrd = 32'h0000_00AA; tbl.push_back(v);
    v = '0; v.srd = 32'h0000_00BB; v.fv = 1; v.frd = 32'h0000_00BB; tbl.push_back(v);
    // no-op write with zero byte enables
    v = '0; v.lreq = 1; v.lwr = 1; v.laddr = 14'h1F; v.lbe = 4'h0; v.lwd = 32'h1234_5678; v.srd = 32'h0000_00CC;
    v.lg = 1; v.sa = 14'h1F; v.swd = 32'h1234_5678; v.swen = 4'h0; v.scs = 1; tbl.push_back(v);
    v = '0; v.srd = 32'h0000_00DD; tbl.push_back(v);

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // contention: fetch 8 cycles, loader on the 9th, period 9
    pf = 1'b0; pl = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      v = '0; v.freq = 1; v.faddr = 14'h21; v.lreq = 1; v.laddr = 14'h5; v.srd = 32'hC000_0000 | c;
      v.lg = (c % 9 == 0); v.fg = !v.lg;
      fill(v);
      run(v, $sformatf("cont%0d", c));
    end
    v = '0; v.srd = 32'h0000_0E0E; fill(v); run(v, "cont_tail");

    // loader blocked 5 cycles, drops, re-requests: needs 8 fresh blocked cycles
    for (int d = 1; d <= 5; d++) begin
      v = '0; v.freq = 1; v.faddr = 14'h30; v.lreq = 1; v.laddr = 14'h6; v.srd = 32'h5000_0000 | d;
      v.fg = 1; fill(v); run(v, $sformatf("drop_pre%0d", d));
    end
    v = '0; v.freq = 1; v.faddr = 14'h30; v.srd = 32'h5000_0006; v.fg = 1; fill(v); run(v, "drop_gap");
    for (int e = 1; e <= 9; e++) begin
      v = '0; v.freq = 1; v.faddr = 14'h31; v.lreq = 1; v.laddr = 14'h6; v.srd = 32'h6000_0000 | e;
      v.lg = (e == 9); v.fg = !v.lg; fill(v); run(v, $sformatf("drop_post%0d", e));
    end
    v = '0; v.srd = 32'h0000_0F0F; fill(v); run(v, "drop_tail");

    // reset right after an accepted fetch read
    v = '0; v.freq = 1; v.faddr = 14'h40; v.srd = 32'h7000_0001; v.fg = 1; fill(v); run(v, "rst_acc");
    v = '0; v.rst = 1; v.freq = 1; v.faddr = 14'h40; v.lreq = 1; v.lwr = 1; v.laddr = 14'h9; v.lbe = 4'hF;
    v.lwd = 32'hFFFF_FFFF; v.srd = 32'h7000_0002; fill(v); run(v, "rst_hold");
    v = '0; v.rst = 1; v.freq = 1; v.faddr = 14'h40; v.srd = 32'h7000_0003; fill(v); run(v, "rst_after");
    v = '0; v.srd = 32'h7000_0004; fill(v); run(v, "rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
